// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: grants one requester at a time, holds until done, withdrawal
// or MAX_HOLD cycles, then inserts one dead cycle and rotates priority.
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  localparam int HCW = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state, state_d;
  logic [N-1:0]     gnt_d;
  logic [IDW-1:0]   gnt_id_d;
  logic             busy_d;
  logic             timeout_d;
  logic [HCW-1:0]   hold_cnt, hold_cnt_d;
  logic [IDW-1:0]   last, last_d;
  logic [IDW-1:0]   winner;

  // First requesting index strictly after lst, wrapping modulo N.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] lst);
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(lst) + 1 + k) % N;
      if (!found && r[idx[IDW-1:0]]) begin
        w     = idx[IDW-1:0];
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign winner = pick(req, last);

  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    gnt_id_d   = gnt_id;
    busy_d     = busy;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt;
    last_d     = last;
    case (state)
      IDLE, RELEASE: begin
        if (|req) begin
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          gnt_id_d      = winner;
          busy_d        = 1'b1;
          hold_cnt_d    = '0;
          state_d       = GRANT;
        end else begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      GRANT: begin
        // done has priority over the hold limit, so a coincident done suppresses timeout.
        if (done[gnt_id] || !req[gnt_id] || hold_cnt == HCW'(MAX_HOLD - 1)) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          last_d    = gnt_id;
          timeout_d = !done[gnt_id] && req[gnt_id];
          state_d   = RELEASE;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last     <= IDW'(N - 1);
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
      busy     <= busy_d;
      timeout  <= timeout_d;
      hold_cnt <= hold_cnt_d;
      last     <= last_d;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (N=4, MAX_HOLD=8); outputs sampled on the falling edge.
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  rr_grant_arbiter #(.N(4), .MAX_HOLD(8), .IDW(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic t);
    chk({tag, "_gnt"}, {28'd0, gnt}, {28'd0, g});
    chk({tag, "_id"}, {30'd0, gnt_id}, {30'd0, id});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, "_tmo"}, {31'd0, timeout}, {31'd0, t});
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] oh;

    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    repeat (2) @(negedge clk);
    chk_out("rst_init", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single request, done on the third grant cycle
    req = 4'b0100;
    step(); chk_out("single_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(); chk_out("single_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(); chk_out("single_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 4'b0100;
    step(); chk_out("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    done = 4'b0000;
    req  = 4'b0000;
    step(); chk_out("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    step(); chk_out("single_idle2", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant
    req = 4'b0100;
    step(); chk_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;

    // Round robin with done on the second grant cycle of each tenure
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << order[k];
      step(); chk_out("rr_c1", oh, 2'(order[k]), 1'b1, 1'b0);
      step(); chk_out("rr_c2", oh, 2'(order[k]), 1'b1, 1'b0);
      done = oh;
      step(); chk_out("rr_rel", 4'b0000, 2'(order[k]), 1'b0, 1'b0);
      done = 4'b0000;
    end

    // Timeout: requester 1 holds for exactly 8 cycles, then requester 3
    req = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      step(); chk_out("tmo_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step(); chk_out("tmo_rel", 4'b0000, 2'd1, 1'b0, 1'b1);
    step(); chk_out("tmo_next", 4'b1000, 2'd3, 1'b1, 1'b0);

    // done on a non-granted bit is ignored; withdrawal releases without timeout
    done = 4'b0010;
    step(); chk_out("ign_done", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 4'b0000;
    req  = 4'b0010;
    step(); chk_out("wdraw_rel", 4'b0000, 2'd3, 1'b0, 1'b0);
    req = 4'b0001;
    step(); chk_out("wdraw_next", 4'b0001, 2'd0, 1'b1, 1'b0);

    // done coinciding with the hold limit wins: no timeout pulse
    repeat (7) begin
      step(); chk_out("coll_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    done = 4'b0001;
    step(); chk_out("coll_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 4'b0000;
    step(); chk_out("coll_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk_out("end_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk_out("end_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
Round-robin arbiter that shares one resource among N requesters, each of which can drive the single-requester grant FSM. It grants one requester at a time and holds the grant until that requester signals done, withdraws its request, or exceeds a maximum hold time. It then rotates priority so every requester is served fairly. It sits between the requester FSMs and the shared resource, and its gnt vector gates each requester's access.

Parameters:
N, 4, number of requesters (2..8)
MAX_HOLD, 8, maximum consecutive grant cycles per tenure (>=1)
IDW, 2, width of gnt_id; must equal clog2(N)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector; bit i = requester i wants the resource
done  input  N  completion pulse; only done[gnt_id] is honoured while granted
gnt  output  N  registered one-hot grant, or all-zero
gnt_id  output  IDW  index of current/last granted requester
busy  output  1  high while any gnt bit is high
timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD

Behaviour:
- One clock (clk) drives the block. Reset is asynchronous and active-low (rst_n).
- Reset (asynchronous, immediate, no clk edge needed):
  - Outputs: gnt=0, gnt_id=0, busy=0, timeout=0.
  - Internal: state=IDLE, hold_cnt=0, last=N-1, so requester 0 has first priority after reset.
- All outputs are registered. There are no combinational input-to-output paths.
- Arbitration function: winner = first i with req[i]=1, scanning (last+1) mod N upward with wrap-around.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req is non-zero at a clk edge: gnt <= onehot(winner), gnt_id <= winner, busy <= 1, hold_cnt <= 0, go to GRANT.
  - Latency: a request sampled at edge k produces gnt high after edge k.
  - If req is zero, stay in IDLE with gnt=0.
- GRANT (evaluated at each edge, first matching rule wins):
  - done[gnt_id]=1 -> go to RELEASE (normal end).
  - req[gnt_id]=0 -> go to RELEASE (withdrawal).
  - hold_cnt==MAX_HOLD-1 -> go to RELEASE and set timeout<=1.
  - Otherwise hold_cnt <= hold_cnt+1 and stay in GRANT.
  - Consequence: gnt is high for at most MAX_HOLD cycles per tenure.
  - done and the timeout limit in the same cycle: done wins, no timeout pulse.
  - done/req changes on non-granted bits are ignored. done while in IDLE or RELEASE is ignored.
- RELEASE (exactly one cycle):
  - gnt=0, busy=0, last=gnt_id (latched on entry). gnt_id holds its value.
  - timeout is high only in this cycle, and only if the tenure timed out.
  - At the next edge, arbitrate with the updated last. If req is non-zero, go directly to GRANT; otherwise go to IDLE.
  - Consequence: consecutive grants are always separated by exactly one dead cycle.
- A requester that keeps req high after release is eligible again only after all other active requesters have been served (rotating priority).
- gnt is always one-hot or zero. This must hold in every cycle, including around reset.
- hold_cnt width is clog2(MAX_HOLD)+1. It never wraps because it is cleared on each grant.

Test Plan:
1. Reset: drive rst_n=0 mid-simulation, between clk edges -> gnt=0, busy=0, timeout=0, gnt_id=0 immediately. After rst_n=1 with req=4'b1111 -> first gnt=4'b0001.
2. Single request: req=4'b0100 at edge k -> gnt=4'b0100, gnt_id=2, busy=1 after edge k. Pulse done[2] in the 3rd grant cycle -> gnt=0 on the next edge, then back to IDLE.
3. Round-robin: req=4'b1111 held, granted requester pulses done on its 2nd grant cycle -> grant order 0,1,2,3,0. Each tenure is 2 cycles high, followed by 1 dead cycle.
4. Timeout: MAX_HOLD=8, req=4'b1010 held, no done -> gnt=4'b0010 high for exactly 8 cycles. timeout=1 for the single RELEASE cycle, then gnt=4'b1000.
5. Withdrawal and ignored done: in a grant to requester 3, pulse done[1] -> no effect. Then drop req[3] -> release on the next edge with timeout=0. With req=4'b0001, the next grant goes to requester 0.
6. Done/timeout collision: assert done[gnt_id] on grant cycle MAX_HOLD -> release with timeout=0.
